// File: rtl/stream_prefetcher.sv
// Next-line / strided stream prefetcher: a miss seeds a generator that queues line
// addresses, and a two-state FSM issues them one at a time. Define PREF_STRIDE_DETECT_EN for stride detection.
module stream_prefetcher #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 32,
   parameter int DEGREE     = 2,
   parameter int QDEPTH     = 4
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              miss_i,
   input  logic [ADDR_W-1:0] miss_addr_i,
   input  logic              flush_i,
   output logic              pref_read_o,
   output logic [ADDR_W-1:0] pref_addr_o,
   input  logic              pref_resp_i,
   output logic              busy_o
);

   localparam int PTR_W = $clog2(QDEPTH);
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_BYTES - 1);

   // One extra bit so an address step can be tested for leaving the address space.
   typedef logic signed [ADDR_W:0] ext_t;
   typedef enum logic {IDLE, REQ} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] gen_addr_q;
   logic [3:0]        gen_left_q;
   logic [ADDR_W-1:0] fifo_mem [QDEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [PTR_W:0]    count_q;

   logic [ADDR_W-1:0] miss_line;
   ext_t              load_stride, gen_stride, load_sum, next_sum;
   logic              fifo_full, fifo_empty, dup, gen_step, push, pop;

   assign miss_line = miss_addr_i & ~OFF_MASK;

`ifdef PREF_STRIDE_DETECT_EN
   ext_t              stride_q, last_delta_q, delta;
   logic [ADDR_W-1:0] last_line_q;
   logic              last_valid_q, delta_valid_q;

   assign delta      = $signed({1'b0, miss_line}) - $signed({1'b0, last_line_q});
   assign gen_stride = stride_q;

   always_comb begin
      // NOTE: default first so every path assigns the signal and no latch is inferred.
      load_stride = ext_t'(LINE_BYTES);
      if (last_valid_q && delta_valid_q && delta == last_delta_q && delta != '0)
         load_stride = delta;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         stride_q      <= ext_t'(LINE_BYTES);
         last_delta_q  <= '0;
         last_line_q   <= '0;
         last_valid_q  <= 1'b0;
         delta_valid_q <= 1'b0;
      end else if (miss_i) begin
         // NOTE: non-blocking so every register samples pre-edge values.
         stride_q     <= load_stride;
         last_line_q  <= miss_line;
         last_valid_q <= 1'b1;
         if (last_valid_q) begin
            last_delta_q  <= delta;
            delta_valid_q <= 1'b1;
         end
      end
   end
`else
   assign load_stride = ext_t'(LINE_BYTES);
   assign gen_stride  = ext_t'(LINE_BYTES);
`endif

   assign load_sum   = $signed({1'b0, miss_line}) + load_stride;
   assign next_sum   = $signed({1'b0, gen_addr_q}) + gen_stride;
   assign fifo_full  = (count_q == (PTR_W+1)'(QDEPTH));
   assign fifo_empty = (count_q == '0);

   // A candidate already queued or currently being fetched is skipped.
   always_comb begin
      dup = (state_q == REQ) && (pref_addr_o == gen_addr_q);
      for (int i = 0; i < QDEPTH; i++)
         if ((PTR_W+1)'(i) < count_q && fifo_mem[rd_ptr_q + PTR_W'(i)] == gen_addr_q)
            dup = 1'b1;
   end

   assign gen_step = (gen_left_q != '0) && !fifo_full && !miss_i && !flush_i;
   assign push     = gen_step && !dup;
   assign pop      = (state_q == IDLE) && !fifo_empty && !flush_i;
   assign busy_o   = (state_q == REQ) || !fifo_empty || (gen_left_q != '0);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         gen_addr_q <= '0;
         gen_left_q <= '0;
      end else if (miss_i) begin
         gen_addr_q <= load_sum[ADDR_W-1:0];
         gen_left_q <= load_sum[ADDR_W] ? 4'd0 : 4'(DEGREE);
      end else if (flush_i) begin
         gen_left_q <= '0;
      end else if (gen_step) begin
         gen_addr_q <= next_sum[ADDR_W-1:0];
         gen_left_q <= next_sum[ADDR_W] ? 4'd0 : gen_left_q - 4'd1;
      end
   end

   // NOTE: storage is not reset; entries are only read when the count says they are valid.
   always_ff @(posedge clk_i) begin
      if (push)
         fifo_mem[wr_ptr_q] <= gen_addr_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         pref_read_o <= 1'b0;
         pref_addr_o <= '0;
      end else begin
         case (state_q)
            IDLE: if (pop) begin
               pref_addr_o <= fifo_mem[rd_ptr_q];
               pref_read_o <= 1'b1;
               state_q     <= REQ;
            end
            REQ: if (pref_resp_i) begin
               pref_read_o <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/stream_prefetcher.md
STREAM_PREFETCHER -- requirements
Module: stream_prefetcher

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width in bits.
REQ-002 SHALL have parameter LINE_BYTES, default 32, cache line size in bytes (power of 2, at least 4).
REQ-003 SHALL have parameter DEGREE, default 2, number of lines prefetched per miss (1..15).
REQ-004 SHALL have parameter QDEPTH, default 4, pending-address FIFO depth (power of 2, at least 2).
REQ-005 SHALL have port clk_i, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n_i, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port miss_i, input, 1 bit, demand-miss strobe sampled each rising edge.
REQ-008 SHALL have port miss_addr_i, input, ADDR_W bits, byte address that missed; valid with miss_i.
REQ-009 SHALL have port flush_i, input, 1 bit, discards pending prefetch work.
REQ-010 SHALL have port pref_read_o, output, 1 bit, prefetch read request to the cache controller.
REQ-011 SHALL have port pref_addr_o, output, ADDR_W bits, line-aligned prefetch address.
REQ-012 SHALL have port pref_resp_i, input, 1 bit, controller signals the prefetch is complete.
REQ-013 SHALL have port busy_o, output, 1 bit, high when a request is outstanding, the FIFO is non-empty, or the generator is active.

Function
REQ-014 SHALL compute the miss line as miss_addr_i with the low log2(LINE_BYTES) bits cleared.
REQ-015 SHALL, on an edge sampling miss_i=1, load the generator with gen_addr=line+stride and gen_left=DEGREE.
REQ-016 SHALL, each cycle with gen_left!=0 and FIFO not full, take gen_addr as the candidate, push it, then advance gen_addr by stride and decrement gen_left.
REQ-017 SHALL skip any candidate equal to a FIFO entry or to an outstanding pref_addr_o; a skipped candidate still consumes one gen_left count, with no push.
REQ-018 SHALL stall the generator while the FIFO is full; no candidate is dropped.
REQ-019 SHALL allow a push and a pop in the same cycle.
REQ-020 SHALL, on a new miss while gen_left!=0, restart the generator from the new miss, abandon remaining candidates, and keep FIFO contents.
REQ-021 SHALL clear gen_left when the next gen_addr would overflow or underflow past the ADDR_W boundary; no wrapped address is issued.
REQ-022 SHALL implement an issue FSM with two states, IDLE and REQ, and reset to IDLE.
REQ-023 SHALL, in IDLE with the FIFO non-empty, pop the head, register it on pref_addr_o, set pref_read_o=1, and move to REQ.
REQ-024 SHALL, in REQ, hold pref_read_o and pref_addr_o stable until an edge samples pref_resp_i=1, then clear pref_read_o and return to IDLE.
REQ-025 SHALL ignore pref_resp_i in IDLE and guarantee at least one low cycle of pref_read_o between requests.
REQ-026 SHALL raise pref_read_o two edges after the edge sampling miss_i when the FIFO is empty and no request is outstanding.
REQ-027 SHALL, on flush_i=1, clear the FIFO and gen_left without aborting an outstanding REQ.
REQ-028 SHALL apply flush before miss when both are sampled on the same edge: the FIFO is cleared and the generator is loaded from the miss.

Reset
REQ-029 SHALL, while rst_n_i=0, without waiting for a clock edge, force pref_read_o=0, pref_addr_o=0, busy_o=0, FSM=IDLE, FIFO empty, gen_left=0, and stride=LINE_BYTES.
REQ-030 SHALL abandon an in-flight request when reset asserts mid-REQ; no response is awaited after release.

Configuration
REQ-031 SHALL, with PREF_STRIDE_DETECT_EN defined, track the signed delta between consecutive miss lines, set stride to that delta once the same non-zero delta occurs twice in succession, apply it to the miss on that same edge, and revert to LINE_BYTES on any mismatch.
REQ-032 SHALL, without PREF_STRIDE_DETECT_EN, use a constant stride of LINE_BYTES and contain no delta registers.

Verification (DEGREE=2, LINE_BYTES=32, QDEPTH=4 unless stated)
REQ-033 SHALL cover: miss 0x1000, FIFO empty and idle -> requests 0x1020 then 0x1040, each held until pref_resp_i; first pref_read_o rises 2 edges after the miss edge.
REQ-034 SHALL cover: miss 0x1000 with pref_resp_i held low, then miss 0x1010 -> both candidates skipped; only 0x1020 and 0x1040 are ever issued.
REQ-035 SHALL cover: DEGREE=8, pref_resp_i low -> 1 outstanding + 4 queued, generator stalls, busy_o=1; on release, 8 requests total, 0x1020..0x1100.
REQ-036 SHALL cover: miss 0xFFFFFFE0 -> no request issued; busy_o returns to 0.
REQ-037 SHALL cover: flush_i during REQ -> current request completes, no further requests; rst_n_i low during REQ -> pref_read_o=0 immediately, with no clock edge.
REQ-038 SHALL cover: misses 0x1000, 0x1100, 0x1200 -> third miss yields 0x1300, 0x1400 with PREF_STRIDE_DETECT_EN, and 0x1220, 0x1240 without.
